ysyx_22041412_rd_arbiter: RTL and testbench

//  Two-master read arbiter for the core's single memory read port. Master IF is the

---
 rtl/ysyx_22041412_rd_arbiter.sv | 108 ++++++++++
 tb/tb_ysyx_22041412_rd_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_rd_arbiter.sv
// Two-master read arbiter: IF and LSU share one memory read port.
// LSU has priority; IF gets a bounded wait and can cancel a fetch in flight.
module ysyx_22041412_rd_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_valid,
  input  logic [AW-1:0] if_req_addr,
  input  logic [7:0]    if_req_size,
  input  logic          if_flush,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          lsu_req_valid,
  input  logic [AW-1:0] lsu_req_addr,
  input  logic [7:0]    lsu_req_size,
  output logic          lsu_rvalid,
  output logic [DW-1:0] lsu_rdata,
  output logic          mem_valid,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_size,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner_lsu
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t        state;
  logic          drop;
  logic [SW-1:0] starve_cnt;
  logic          any_req;
  logic          if_turn;
  logic          lsu_win;

  assign any_req = if_req_valid | lsu_req_valid;
  assign if_turn = (STARVE_MAX != 0) && (starve_cnt == SMAX);
  assign lsu_win = lsu_req_valid && !(if_req_valid && if_turn);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      drop       <= 1'b0;
      starve_cnt <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_size   <= '0;
      owner_lsu  <= 1'b0;
      if_rvalid  <= 1'b0;
      lsu_rvalid <= 1'b0;
      if_rdata   <= '0;
      lsu_rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state     <= BUSY;
            mem_valid <= 1'b1;
            owner_lsu <= lsu_win;
            mem_addr  <= lsu_win ? lsu_req_addr : if_req_addr;
            mem_size  <= lsu_win ? lsu_req_size : if_req_size;
            // saturating count of LSU wins over a waiting IF
            if (lsu_win && if_req_valid) begin
              if (starve_cnt != SMAX)
                starve_cnt <= starve_cnt + SW'(1);
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        BUSY: begin
          if (if_flush && !owner_lsu)
            drop <= 1'b1;
          if (mem_ready) begin
            state     <= RESP;
            mem_valid <= 1'b0;
            if (owner_lsu) begin
              lsu_rdata  <= mem_rdata;
              lsu_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= !drop;
            end
          end
        end
        RESP: begin
          state      <= IDLE;
          drop       <= 1'b0;
          if_rvalid  <= 1'b0;
          lsu_rvalid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_rd_arbiter.sv
// Scoreboard bench for the two-master read arbiter.
// Stimulus queues expected grants/data; a negedge monitor pops and compares.
module tb_ysyx_22041412_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_valid = 1'b0;
  logic [31:0] if_req_addr = '0;
  logic [7:0]  if_req_size = '0;
  logic        if_flush = 1'b0;
  logic        if_rvalid;
  logic [63:0] if_rdata;
  logic        lsu_req_valid = 1'b0;
  logic [31:0] lsu_req_addr = '0;
  logic [7:0]  lsu_req_size = '0;
  logic        lsu_rvalid;
  logic [63:0] lsu_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [7:0]  mem_size;
  logic        mem_ready = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        busy;
  logic        owner_lsu;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        lsu;
    logic [7:0]  size;
    logic [31:0] addr;
  } grant_t;

  grant_t      grant_q[$];
  logic [63:0] if_q[$];
  logic [63:0] lsu_q[$];
  grant_t      mon_g;
  logic [63:0] mon_d;
  logic        prev_mv = 1'b0;

  logic auto_mem = 1'b1;
  int   lat = 2;
  int   mcnt = 0;

  ysyx_22041412_rd_arbiter #(
    .AW(32), .DW(64), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .if_req_size(if_req_size), .if_flush(if_flush),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr),
    .lsu_req_size(lsu_req_size),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .owner_lsu(owner_lsu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s got event want none/other", name);
  endtask

  function automatic logic [63:0] mem_fn(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 64'h413 : {32'h5A5A_0000, a};
  endfunction

  function automatic logic sig(input int w);
    case (w)
      0:       return if_rvalid;
      1:       return lsu_rvalid;
      2:       return mem_valid;
      default: return !mem_valid;
    endcase
  endfunction

  task automatic wait_sig(input int w, input string name, input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!sig(w) && n < budget);
    if (!sig(w)) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got 0 want 1", name);
    end
  endtask

  // memory model: answers lat cycles after mem_valid rises
  initial forever begin
    @(posedge clk);
    #1;
    if (auto_mem) begin
      mem_ready = 1'b0;
      if (mem_valid) begin
        if (mcnt == lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_fn(mem_addr);
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_valid && !prev_mv) begin
      if (grant_q.size() == 0) miss("grant_unexpected");
      else begin
        mon_g = grant_q.pop_front();
        chk("grant", {23'd0, owner_lsu, mem_size, mem_addr}, {23'd0, mon_g});
      end
    end
    prev_mv = mem_valid;
    if (if_rvalid) begin
      if (if_q.size() == 0) miss("if_rvalid_unexpected");
      else begin
        mon_d = if_q.pop_front();
        chk("if_rdata", if_rdata, mon_d);
      end
    end
    if (lsu_rvalid) begin
      if (lsu_q.size() == 0) miss("lsu_rvalid_unexpected");
      else begin
        mon_d = lsu_q.pop_front();
        chk("lsu_rdata", lsu_rdata, mon_d);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", {59'd0, mem_valid, if_rvalid, lsu_rvalid, busy, owner_lsu}, 0);
    chk("rst_mem", {24'd0, mem_size, mem_addr}, 0);
    chk("rst_rdata", if_rdata | lsu_rdata, 0);
    chk("rst_starve", dut.starve_cnt, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: IF only
    grant_q.push_back({1'b0, 8'h0F, 32'h8000_0000});
    if_q.push_back(64'h0000_0000_0000_0413);
    if_req_addr = 32'h8000_0000;
    if_req_size = 8'h0F;
    if_req_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("t1_latency", mem_valid, 1);
    wait_sig(0, "t1_if", 20);
    if_req_valid = 1'b0;
    @(posedge clk);
    #1;

    // T2: simultaneous requests, LSU first then IF immediately
    grant_q.push_back({1'b1, 8'hFF, 32'h8000_1000});
    grant_q.push_back({1'b0, 8'h0F, 32'h8000_0004});
    lsu_q.push_back(64'h5A5A_0000_8000_1000);
    if_q.push_back(64'h5A5A_0000_8000_0004);
    if_req_addr = 32'h8000_0004;
    lsu_req_addr = 32'h8000_1000;
    lsu_req_size = 8'hFF;
    if_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    wait_sig(1, "t2_lsu", 20);
    lsu_req_valid = 1'b0;
    chk("t2_starve1", dut.starve_cnt, 1);
    @(posedge clk);
    #1;
    chk("t2_idle", busy, 0);
    @(posedge clk);
    #1;
    chk("t2_if_next", {31'd0, mem_valid, mem_addr}, {31'd0, 1'b1, 32'h8000_0004});
    wait_sig(0, "t2_if", 20);
    if_req_valid = 1'b0;
    chk("t2_starve0", dut.starve_cnt, 0);
    @(posedge clk);
    #1;

    // T3: starvation bound of 4
    for (int i = 0; i < 4; i++) begin
      grant_q.push_back({1'b1, 8'hFF, 32'h8000_2000 + 32'(i * 8)});
      lsu_q.push_back({32'h5A5A_0000, 32'h8000_2000 + 32'(i * 8)});
    end
    grant_q.push_back({1'b0, 8'h0F, 32'h8000_0008});
    if_q.push_back(64'h5A5A_0000_8000_0008);
    grant_q.push_back({1'b1, 8'hFF, 32'h8000_2020});
    lsu_q.push_back(64'h5A5A_0000_8000_2020);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          lsu_req_addr = 32'h8000_2000 + 32'(i * 8);
          lsu_req_valid = 1'b1;
          wait_sig(1, "t3_lsu", 40);
          if (i == 3) chk("t3_starve_max", dut.starve_cnt, 4);
        end
        lsu_req_valid = 1'b0;
      end
      begin
        if_req_addr = 32'h8000_0008;
        if_req_valid = 1'b1;
        wait_sig(0, "t3_if", 150);
        chk("t3_starve_clr", dut.starve_cnt, 0);
        if_req_valid = 1'b0;
      end
    join
    @(posedge clk);
    #1;

    // T4: flush drops the fetch, then a normal fetch
    lat = 3;
    grant_q.push_back({1'b0, 8'h0F, 32'h8000_0040});
    if_req_addr = 32'h8000_0040;
    if_req_valid = 1'b1;
    wait_sig(2, "t4_grant", 10);
    if_flush = 1'b1;
    if_req_valid = 1'b0;
    @(posedge clk);
    #1;
    if_flush = 1'b0;
    wait_sig(3, "t4_mem_drop", 20);
    chk("t4_resp", {62'd0, busy, if_rvalid}, {62'd0, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    chk("t4_idle", busy, 0);
    lat = 2;
    grant_q.push_back({1'b0, 8'h0F, 32'h8000_0100});
    if_q.push_back(64'h5A5A_0000_8000_0100);
    if_req_addr = 32'h8000_0100;
    if_req_valid = 1'b1;
    wait_sig(0, "t4_refetch", 20);
    if_req_valid = 1'b0;
    @(posedge clk);
    #1;

    // T5: reset while LSU owns the bus
    auto_mem = 1'b0;
    mem_ready = 1'b0;
    grant_q.push_back({1'b1, 8'hFF, 32'h8000_3000});
    lsu_req_addr = 32'h8000_3000;
    lsu_req_valid = 1'b1;
    wait_sig(2, "t5_grant", 10);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lsu_req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("t5_reset", {60'd0, mem_valid, lsu_rvalid, busy, owner_lsu}, 0);

    // T6: stray mem_ready in IDLE and RESP
    mem_rdata = 64'hDEAD_BEEF;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    chk("t6_idle_ready", {61'd0, busy, if_rvalid, lsu_rvalid}, 0);
    chk("t6_lsu_rdata", lsu_rdata, 0);
    grant_q.push_back({1'b0, 8'h0F, 32'h8000_0200});
    if_q.push_back(64'h1122_3344_5566_7788);
    if_req_addr = 32'h8000_0200;
    if_req_valid = 1'b1;
    wait_sig(2, "t6_grant", 10);
    mem_rdata = 64'h1122_3344_5566_7788;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    chk("t6_rvalid", if_rvalid, 1);
    if_req_valid = 1'b0;
    mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    chk("t6_resp_ready", {62'd0, busy, if_rvalid}, 0);
    chk("t6_rdata_hold", if_rdata, 64'h1122_3344_5566_7788);

    repeat (3) @(posedge clk);
    #1;
    chk("grant_q_empty", grant_q.size(), 0);
    chk("if_q_empty", if_q.size(), 0);
    chk("lsu_q_empty", lsu_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
